pipe_stage_reg: RTL

Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer. It replaces the fixed 32-bit stall/flush register pair between pipeline stages, for example fetch→decode and decode→execute. Payload width and bubble value are parameters, and backpressure is registered so no combinational ready path crosses the stage. Flush injects a bubble, and an explicit stall input holds the stage.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_stage_stats.sv | 47 ++++
 rtl/pipe_stage_reg.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the pipeline stage register:
//   NOP            - RV32 canonical no-op (addi x0, x0, 0)
//   pipe_state_e   - occupancy of the stage (EMPTY / ONE / FULL)
//   pc_inst_bubble - builds a {pc, inst} bubble payload with a NOP instruction
package pipe_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  // Default bubble for a fetch->decode style {pc, inst} payload.
  function automatic logic [63:0] pc_inst_bubble(input logic [31:0] pc);
    return {pc, NOP};
  endfunction

endpackage

// File: rtl/pipe_stage_stats.sv
// pipe_stage_stats
// Saturating event counters for a pipeline stage. Only built when the
// PIPE_STAGE_STATS_EN macro is defined in the including design.
// Ports:
//   clk, nrst       - clock, synchronous active-low reset (counters clear to 0)
//   stall_cycle_i   - count one stalled cycle
//   flush_i         - count one flush cycle
//   stall_cycles_o  - stalled-cycle count, saturates at 32'hFFFF_FFFF
//   flush_count_o   - flush count, saturates at 32'hFFFF_FFFF
module pipe_stage_stats (
  input  logic        clk,
  input  logic        nrst,
  input  logic        stall_cycle_i,
  input  logic        flush_i,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_count_o
);

  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Increment on the event, but stick at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_cycle_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush_i && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_count_o  = flush_cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Pipeline stage register with valid/ready handshake and a 2-entry skid
// buffer (main + skid). All outputs come straight from flops, so there is
// no combinational path from out_ready/stall/flush to any output.
// Parameters:
//   DATA_W      - payload width
//   BUBBLE_DATA - payload shown on out_data while out_valid=0
// Ports:
//   clk, nrst           - clock, synchronous active-low reset
//   stall               - hold: downstream is treated as not ready
//   flush               - drop all held beats, present a bubble next cycle
//   in_valid/in_ready   - upstream handshake, in_data payload
//   out_valid/out_ready - downstream handshake, out_data payload
// Optional (macro PIPE_STAGE_STATS_EN):
//   stat_stall_cycles   - cycles with out_valid & ~out_fire & ~flush
//   stat_flush_count    - cycles with flush=1
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W      = 64,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(pc_inst_bubble(32'd0))
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]       stat_stall_cycles,
  output logic [31:0]       stat_flush_count
`endif
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic in_fire;
  logic out_fire;

  // Stall masks the downstream side only; upstream accepts still proceed.
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready & ~stall;

  // Next-state and datapath. Flush overrides everything: the stage empties
  // and any beat accepted in the same cycle is dropped. The skid entry is
  // only ever read in FULL, so it is simply left stale when not in use.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE_DATA;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = BUBBLE_DATA;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE_DATA;
        end
      endcase
    end
    // Handshake flags are precomputed from the next state so they can be
    // registered alongside it.
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= EMPTY;
      main_q      <= BUBBLE_DATA;
      skid_q      <= BUBBLE_DATA;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

`ifdef PIPE_STAGE_STATS_EN
  logic stall_cycle;

  // A stalled cycle: something is on offer but it did not leave, and the
  // cycle is not being flushed away.
  assign stall_cycle = out_valid_q & ~out_fire & ~flush;

  pipe_stage_stats u_stats (
    .clk            (clk),
    .nrst           (nrst),
    .stall_cycle_i  (stall_cycle),
    .flush_i        (flush),
    .stall_cycles_o (stat_stall_cycles),
    .flush_count_o  (stat_flush_count)
  );
`endif

endmodule
